// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the 8-bit ALU command interface.
// Accepts encoded instructions, reads operands from a local 4-entry register
// file, drives the clocked ALU, waits RESULT_LATENCY cycles, then writes the
// result back and pulses done.
//
// Optional build macro: ALU_ISSUE_PERF_CNT_EN enables the saturating
// completed-instruction counter on instr_count (tied to 0 otherwise).
//
// state | meaning
// IDLE  | ready for an instruction; operands latched on acceptance
// ISSUE | ALU inputs stable, ALU samples them at the end of this cycle
// WAIT  | result latency countdown; capture and writeback when count is 1
module alu_issue_ctrl #(
    parameter int DATA_W         = 8,
    parameter int RESULT_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic              host_wr_en,
    input  logic [1:0]        host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic [1:0]        host_rd_addr,
    output logic [DATA_W-1:0] host_rd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic [2:0]        alu_shift,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_barrel_a,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    output logic              done,
    output logic              busy,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              overflow_flag,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf [0:3];
    logic [2:0]        cnt_q;
    logic [1:0]        rd_q;
    logic [2:0]        op_q;
    logic              accept;
    logic              capture;
    logic [DATA_W-1:0] wb_data;
    logic              unused_reserved;

    // Reserved encoding bits carry no meaning.
    assign unused_reserved = ^instr[3:0];

    assign host_rd_data = rf[host_rd_addr];
    assign wb_data      = (op_q == 3'd7) ? alu_barrel_a : alu_result;

    // Next-state decode and handshake/status outputs.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        busy        = 1'b1;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = instr_valid & instr_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand/opcode latching and latency countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_shift <= '0;
            rd_q      <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                alu_op    <= instr[15:13];
                alu_shift <= instr[12:10];
                rd_q      <= instr[9:8];
                op_q      <= instr[15:13];
                alu_a     <= rf[instr[7:6]];
                alu_b     <= rf[instr[5:4]];
            end
            if (state_q == ISSUE)     cnt_q <= 3'(RESULT_LATENCY);
            else if (state_q == WAIT) cnt_q <= cnt_q - 3'd1;
        end
    end

    // Register file: writeback is applied last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            if (host_wr_en) rf[host_wr_addr] <= host_wr_data;
            if (capture)    rf[rd_q]         <= wb_data;
        end
    end

    // Result flags and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= capture;
            if (capture) begin
                zero_flag <= (wb_data == '0);
                case (op_q)
                    3'd0, 3'd3: begin
                        carry_flag    <= alu_carry;
                        overflow_flag <= alu_overflow;
                    end
                    3'd7: ;
                    default: begin
                        carry_flag    <= 1'b0;
                        overflow_flag <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [15:0] perf_cnt_q;

    // Saturating count of completed instructions.
    always_ff @(posedge clk) begin
        if (rst)                                  perf_cnt_q <= '0;
        else if (capture && perf_cnt_q != 16'hFFFF) perf_cnt_q <= perf_cnt_q + 16'd1;
    end

    assign instr_count = perf_cnt_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: two instances (result latency 1
// and 3) driven by directed instructions; expected completions are queued
// at acceptance and checked by per-instance monitors when done pulses.
module tb_alu_issue_ctrl;

    typedef struct {
        int         acc;
        logic [7:0] val;
        logic       z;
        logic       c;
        logic       o;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t q1[$];
    exp_t q3[$];

    // Latency-1 instance signals
    logic        rst1, valid1, ready1, hwe1, done1, busy1, z1, c1, o1;
    logic        carry1, ovf1;
    logic [15:0] instr1, cnt1;
    logic [1:0]  hwa1, hra1;
    logic [7:0]  hwd1, hrd1, a1, b1, res1, bar1;
    logic [2:0]  op1, sh1;

    // Latency-3 instance signals
    logic        rst3, valid3, ready3, hwe3, done3, busy3, z3, c3, o3;
    logic        carry3, ovf3;
    logic [15:0] instr3, cnt3;
    logic [1:0]  hwa3, hra3;
    logic [7:0]  hwd3, hrd3, a3, b3, res3, bar3;
    logic [2:0]  op3, sh3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl #(.DATA_W(8), .RESULT_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .instr_valid(valid1), .instr(instr1), .instr_ready(ready1),
        .host_wr_en(hwe1), .host_wr_addr(hwa1), .host_wr_data(hwd1),
        .host_rd_addr(hra1), .host_rd_data(hrd1),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_shift(sh1),
        .alu_result(res1), .alu_barrel_a(bar1), .alu_carry(carry1), .alu_overflow(ovf1),
        .done(done1), .busy(busy1), .zero_flag(z1), .carry_flag(c1), .overflow_flag(o1),
        .instr_count(cnt1));

    alu_issue_ctrl #(.DATA_W(8), .RESULT_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .instr_valid(valid3), .instr(instr3), .instr_ready(ready3),
        .host_wr_en(hwe3), .host_wr_addr(hwa3), .host_wr_data(hwd3),
        .host_rd_addr(hra3), .host_rd_data(hrd3),
        .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_shift(sh3),
        .alu_result(res3), .alu_barrel_a(bar3), .alu_carry(carry3), .alu_overflow(ovf3),
        .done(done3), .busy(busy3), .zero_flag(z3), .carry_flag(c3), .overflow_flag(o3),
        .instr_count(cnt3));

    // Bench ALU: {carry, overflow, result, barrel}. Inputs are held stable
    // through WAIT, so a combinational model stands in for the clocked ALU.
    function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [2:0] sh);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        s = {1'b0, a} + {1'b0, b};
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin r = s[7:0]; c = s[8]; v = ~(a[7] ^ b[7]) & (a[7] ^ r[7]); end
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: begin r = a - b; c = (a < b); v = (a[7] ^ b[7]) & (a[7] ^ r[7]); end
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = a >> sh;
            default: r = a;
        endcase
        return {c, v, r, 8'(a << sh)};
    endfunction

    always_comb {carry1, ovf1, res1, bar1} = alu_f(op1, a1, b1, sh1);
    always_comb {carry3, ovf3, res3, bar3} = alu_f(op3, a3, b3, sh3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the latency-1 instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut1_unexpected_done at cycle %0d: got done=1 expected 0", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_done_cycle", 32'(cyc), 32'(e.acc + 2));
                    chk("dut1_wb_data", 32'(hrd1), 32'(e.val));
                    chk("dut1_zero", 32'(z1), 32'(e.z));
                    chk("dut1_carry", 32'(c1), 32'(e.c));
                    chk("dut1_ovf", 32'(o1), 32'(e.o));
                end
            end
        end
    end

    // Monitor for the latency-3 instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done3 === 1'b1) begin
                if (q3.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut3_unexpected_done at cycle %0d: got done=1 expected 0", cyc);
                end else begin
                    e = q3.pop_front();
                    chk("dut3_done_cycle", 32'(cyc), 32'(e.acc + 4));
                    chk("dut3_wb_data", 32'(hrd3), 32'(e.val));
                    chk("dut3_zero", 32'(z3), 32'(e.z));
                    chk("dut3_carry", 32'(c3), 32'(e.c));
                    chk("dut3_ovf", 32'(o3), 32'(e.o));
                end
            end
        end
    end

    task automatic hwrite1(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        hwe1 = 1'b1; hwa1 = addr; hwd1 = data;
        @(negedge clk);
        hwe1 = 1'b0;
    endtask

    task automatic hwrite3(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        hwe3 = 1'b1; hwa3 = addr; hwd3 = data;
        @(negedge clk);
        hwe3 = 1'b0;
    endtask

    // Offer an instruction to dut1; returns #1 after the acceptance edge.
    task automatic issue1(input logic [15:0] ins, input logic [1:0] rd, input logic push,
                          input logic [7:0] ev, input logic ez, input logic ec, input logic eo);
        int   n;
        exp_t e;
        @(negedge clk);
        hra1 = rd; instr1 = ins; valid1 = 1'b1;
        n = 0;
        while (!ready1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL dut1_accept_timeout: got ready=0 expected 1");
        end
        @(posedge clk); #1;
        valid1 = 1'b0; instr1 = 16'h0000;
        if (push) begin
            e.acc = cyc; e.val = ev; e.z = ez; e.c = ec; e.o = eo;
            q1.push_back(e);
        end
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 30) begin @(negedge clk); n++; end
        if (q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL dut1_done_timeout: got pending=%0d expected 0", q1.size());
            q1.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic drain3();
        int n = 0;
        while (q3.size() != 0 && n < 40) begin @(negedge clk); n++; end
        if (q3.size() != 0) begin
            checks++; errors++;
            $display("FAIL dut3_done_timeout: got pending=%0d expected 0", q3.size());
            q3.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n, acc_a, acc_b;
        exp_t e;
        rst1 = 1'b1; valid1 = 1'b0; instr1 = '0; hwe1 = 1'b0; hwa1 = '0; hwd1 = '0; hra1 = '0;
        rst3 = 1'b1; valid3 = 1'b0; instr3 = '0; hwe3 = 1'b0; hwa3 = '0; hwd3 = '0; hra3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(ready1), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_alu_a", 32'(a1), 32'd0);
        chk("rst_alu_b", 32'(b1), 32'd0);
        chk("rst_alu_op", 32'(op1), 32'd0);
        chk("rst_alu_shift", 32'(sh1), 32'd0);
        chk("rst_flags", 32'({z1, c1, o1}), 32'd0);
        chk("rst_count", 32'(cnt1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            hra1 = 2'(i); #1;
            chk("rst_rf", 32'(hrd1), 32'd0);
        end

        // Reset asserted during WAIT aborts with no writeback and no done
        hwrite1(2'd1, 8'h05);
        hwrite1(2'd2, 8'h07);
        issue1(16'h0360, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("midwait_busy", 32'(busy1), 32'd1);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        chk("midwait_ready", 32'(ready1), 32'd1);
        chk("midwait_busy_after", 32'(busy1), 32'd0);
        chk("midwait_done", 32'(done1), 32'd0);
        chk("midwait_flags", 32'({z1, c1, o1}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            hra1 = 2'(i); #1;
            chk("midwait_rf", 32'(hrd1), 32'd0);
        end
        repeat (3) @(negedge clk);

        // ADD 0x7F + 0x01 with a same-edge host write to rd (writeback wins)
        hwrite1(2'd1, 8'h7F);
        hwrite1(2'd2, 8'h01);
        issue1(16'h0360, 2'd3, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        hwe1 = 1'b1; hwa1 = 2'd3; hwd1 = 8'hAA;
        @(negedge clk);
        hwe1 = 1'b0;
        drain1();

        // Same ADD again; host writes r1 on the writeback edge, both land
        issue1(16'h0360, 2'd3, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        hwe1 = 1'b1; hwa1 = 2'd1; hwd1 = 8'h55;
        @(negedge clk);
        hwe1 = 1'b0;
        drain1();
        hra1 = 2'd1; #1;
        chk("collision_r1", 32'(hrd1), 32'h55);

        // SUB to zero; operands held through ISSUE and WAIT
        hwrite1(2'd1, 8'h10);
        hwrite1(2'd2, 8'h10);
        issue1(16'h6060, 2'd0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("sub_issue_a", 32'(a1), 32'h10);
        chk("sub_issue_b", 32'(b1), 32'h10);
        @(negedge clk);
        chk("sub_wait_a", 32'(a1), 32'h10);
        chk("sub_wait_b", 32'(b1), 32'h10);
        chk("sub_wait_op", 32'(op1), 32'd3);
        drain1();

        // ADD 0x80 + 0x80 sets carry and overflow
        hwrite1(2'd1, 8'h80);
        hwrite1(2'd2, 8'h80);
        issue1(16'h0360, 2'd3, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        drain1();

        // Barrel shift keeps carry/overflow from the previous ADD
        hwrite1(2'd1, 8'h03);
        issue1(16'hEA40, 2'd2, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("barrel_shift", 32'(sh1), 32'd2);
        chk("barrel_op", 32'(op1), 32'd7);
        drain1();

        // AND r1 = r2 & r3 = 0x0C & 0x00 clears carry/overflow
        issue1(16'h21B0, 2'd1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        drain1();

        // Latency 3, back-to-back: ADD r3 = 0x22 + 0x11, then SUB r0 = 0x22 - 0x11
        hwrite3(2'd1, 8'h22);
        hwrite3(2'd2, 8'h11);
        @(negedge clk);
        hra3 = 2'd3; instr3 = 16'h0360; valid3 = 1'b1;
        n = 0;
        while (!ready3 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        acc_a = cyc;
        e.acc = acc_a; e.val = 8'h33; e.z = 1'b0; e.c = 1'b0; e.o = 1'b0;
        q3.push_back(e);
        instr3 = 16'h6060;
        @(negedge clk);
        n = 0;
        while (!ready3 && n < 20) begin @(negedge clk); n++; end
        chk("lat3_accept_in_done", 32'(done3), 32'd1);
        @(posedge clk); #1;
        acc_b = cyc;
        e.acc = acc_b; e.val = 8'h11; e.z = 1'b0; e.c = 1'b0; e.o = 1'b0;
        q3.push_back(e);
        valid3 = 1'b0; instr3 = 16'h0000;
        hra3 = 2'd0;
        chk("lat3_second_accept", 32'(acc_b - acc_a), 32'd5);
        drain3();
        hra3 = 2'd3; #1;
        chk("lat3_rf3", 32'(hrd3), 32'h33);
        hra3 = 2'd0; #1;
        chk("lat3_rf0", 32'(hrd3), 32'h11);
`ifdef ALU_ISSUE_PERF_CNT_EN
        chk("lat3_instr_count", 32'(cnt3), 32'd2);
`else
        chk("lat3_instr_count", 32'(cnt3), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
